// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// I2C target with a DEPTH x 8 register bank at DEV_ADDR; optional SCL/SDA glitch filter via I2C_TGT_GLITCH_FILTER_EN.
// Latency: pins seen 2 clk after a change (4 with the filter); sda_oe updates 1 clk after a seen SCL fall.
// Backpressure: none; SCL is never stretched and every committed byte produces exactly one wr_strobe.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h39,
    parameter int         DEPTH    = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] loc_addr,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [3:0] {
        IDLE, DEVADDR, DEVACK, REGADDR, REGACK, WRDATA, WRACK, RDDATA, RDACK, IGNORE
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_c, sda_c;
    logic       scl_q, sda_q;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_t     state, state_n;
    logic [3:0] bit_cnt, cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] ptr, ptr_n;
    logic       oe_n;
    logic       wr_en;
    logic [7:0] rd_byte;
    logic [7:0] regs [DEPTH];

    // Synchronizers reset to the idle-high bus level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic scl_pend, sda_pend;

    // A differing sample must persist for a further two clk before the conditioned line follows.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_c    <= 1'b1;
            sda_c    <= 1'b1;
            scl_pend <= 1'b0;
            sda_pend <= 1'b0;
        end else begin
            if (scl_sync[1] == scl_c) begin
                scl_pend <= 1'b0;
            end else if (scl_pend) begin
                scl_c    <= scl_sync[1];
                scl_pend <= 1'b0;
            end else begin
                scl_pend <= 1'b1;
            end
            if (sda_sync[1] == sda_c) begin
                sda_pend <= 1'b0;
            end else if (sda_pend) begin
                sda_c    <= sda_sync[1];
                sda_pend <= 1'b0;
            end else begin
                sda_pend <= 1'b1;
            end
        end
    end
`else
    assign scl_c = scl_sync[1];
    assign sda_c = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_c;
            sda_q <= sda_c;
        end
    end

    assign scl_rise  = scl_c & ~scl_q;
    assign scl_fall  = ~scl_c & scl_q;
    assign start_det = scl_c & scl_q & sda_q & ~sda_c;
    assign stop_det  = scl_c & scl_q & ~sda_q & sda_c;

    assign rd_byte   = regs[ptr[AW-1:0]];
    assign loc_rdata = regs[loc_addr[AW-1:0]];

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        shift_n = shift;
        ptr_n   = ptr;
        oe_n    = sda_oe;
        wr_en   = 1'b0;
        if (stop_det) begin
            state_n = IDLE;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else if (start_det) begin
            state_n = DEVADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else begin
            case (state)
                DEVADDR, REGADDR, WRDATA: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_c};
                        cnt_n   = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        // This fall opens the ACK slot for the byte just shifted in.
                        cnt_n = '0;
                        oe_n  = 1'b1;
                        if (state == DEVADDR) begin
                            if (shift[7:1] == DEV_ADDR) begin
                                state_n = DEVACK;
                            end else begin
                                state_n = IGNORE;
                                oe_n    = 1'b0;
                            end
                        end else if (state == REGADDR) begin
                            ptr_n   = shift;
                            state_n = REGACK;
                        end else begin
                            wr_en   = 1'b1;
                            ptr_n   = ptr + 8'd1;
                            state_n = WRACK;
                        end
                    end
                end
                DEVACK: begin
                    if (scl_fall) begin
                        if (shift[0]) begin
                            state_n = RDDATA;
                            shift_n = rd_byte;
                            oe_n    = ~rd_byte[7];
                        end else begin
                            state_n = REGADDR;
                            oe_n    = 1'b0;
                        end
                    end
                end
                REGACK, WRACK: begin
                    if (scl_fall) begin
                        state_n = WRDATA;
                        oe_n    = 1'b0;
                    end
                end
                RDDATA: begin
                    if (scl_rise) begin
                        cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n = RDACK;
                            cnt_n   = '0;
                            oe_n    = 1'b0;
                        end else begin
                            shift_n = {shift[6:0], 1'b0};
                            oe_n    = ~shift[6];
                        end
                    end
                end
                RDACK: begin
                    // bit_cnt == 1 marks an ACK already sampled; the following fall starts the next byte.
                    if (scl_rise) begin
                        if (sda_c) begin
                            state_n = IGNORE;
                        end else begin
                            ptr_n = ptr + 8'd1;
                            cnt_n = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state_n = RDDATA;
                        cnt_n   = '0;
                        shift_n = rd_byte;
                        oe_n    = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= cnt_n;
            shift     <= shift_n;
            ptr       <= ptr_n;
            sda_oe    <= oe_n;
            wr_strobe <= wr_en;
            if (wr_en) begin
                wr_addr <= ptr;
                wr_data <= shift;
            end
            if (start_det) begin
                busy <= 1'b1;
            end else if (stop_det) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[ptr[AW-1:0]] <= shift;
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// Directed bench for i2c_target_regs: bit-banged initiator on a wired-AND SDA line, strobe log, inline checks.
module tb_i2c_target_regs;

    localparam int Q = 80;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_strobe, busy;
    logic [7:0] loc_addr = 8'h00;
    logic [7:0] loc_rdata, wr_addr, wr_data;

    int checks = 0;
    int failures = 0;
    int st_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] st_a [64];
    logic [7:0] st_d [64];

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs #(.DEV_ADDR(7'h39), .DEPTH(64)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            if (st_cnt < 64) begin
                st_a[st_cnt] = wr_addr;
                st_d[st_cnt] = wr_data;
            end
            st_cnt++;
        end
        if (sda_oe) oe_cnt++;
    end

    task automatic bus_start;
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic bus_bit(input logic b, input logic glitch, output logic r);
        sda_m = b; #Q;
        scl_m = 1'b1; #Q;
        r = sda_line;
        if (glitch) begin
            scl_m = 1'b0; #10;
            scl_m = 1'b1;
        end
        #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_wbyte(input logic [7:0] d, input logic glitch, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], glitch && (i == 7), r);
        bus_bit(1'b1, 1'b0, ack);
    endtask

    task automatic bus_rbyte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, r);
            d[i] = r;
        end
        bus_bit(mack, 1'b0, r);
    endtask

    task automatic loc_read(input logic [7:0] a, output logic [7:0] d);
        loc_addr = a;
        @(negedge clk);
        d = loc_rdata;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
        checks++; if ({wr_addr, wr_data} !== 16'h0000) begin failures++; $display("FAIL reset_wr_addr_data: got %h expected 0000", {wr_addr, wr_data}); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        loc_read(8'h10, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_reg10: got %h expected 00", d); end
    endtask

    task automatic test_multi_write;
        logic a0, a1, a2, a3;
        logic [7:0] d;
        int base = st_cnt;
        bus_start;
        bus_wbyte(8'h72, 1'b0, a0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b expected 1", busy); end
        bus_wbyte(8'h10, 1'b0, a1);
        bus_wbyte(8'hA5, 1'b0, a2);
        bus_wbyte(8'h5A, 1'b0, a3);
        bus_stop;
        repeat (8) @(negedge clk);
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("FAIL write_acks: got %b expected 0000", {a0, a1, a2, a3}); end
        checks++; if (st_cnt - base !== 2) begin failures++; $display("FAIL write_strobe_count: got %0d expected 2", st_cnt - base); end
        checks++; if ({st_a[base], st_d[base]} !== 16'h10A5) begin failures++; $display("FAIL write_strobe0: got %h expected 10a5", {st_a[base], st_d[base]}); end
        checks++; if ({st_a[base+1], st_d[base+1]} !== 16'h115A) begin failures++; $display("FAIL write_strobe1: got %h expected 115a", {st_a[base+1], st_d[base+1]}); end
        loc_read(8'h10, d);
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL write_reg10: got %h expected a5", d); end
        loc_read(8'h11, d);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL write_reg11: got %h expected 5a", d); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_read_rs;
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        int base = st_cnt;
        bus_start;
        bus_wbyte(8'h72, 1'b0, a0);
        bus_wbyte(8'h11, 1'b0, a1);
        bus_start;
        bus_wbyte(8'h73, 1'b0, a2);
        bus_rbyte(1'b0, d0);
        bus_rbyte(1'b1, d1);
        bus_stop;
        repeat (8) @(negedge clk);
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL read_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (d0 !== 8'h5A) begin failures++; $display("FAIL read_byte0: got %h expected 5a", d0); end
        checks++; if (d1 !== 8'h00) begin failures++; $display("FAIL read_byte1: got %h expected 00", d1); end
        checks++; if (st_cnt - base !== 0) begin failures++; $display("FAIL read_no_strobe: got %0d expected 0", st_cnt - base); end
    endtask

    task automatic test_addr_mismatch;
        logic a0, a1;
        logic [7:0] d;
        int base = st_cnt;
        int oe_base = oe_cnt;
        bus_start;
        bus_wbyte(8'h74, 1'b0, a0);
        checks++; if (a0 !== 1'b1) begin failures++; $display("FAIL mismatch_nack: got %b expected 1", a0); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mismatch_busy: got %b expected 1", busy); end
        bus_wbyte(8'h10, 1'b0, a1);
        bus_wbyte(8'hFF, 1'b0, a1);
        bus_stop;
        repeat (8) @(negedge clk);
        checks++; if (oe_cnt - oe_base !== 0) begin failures++; $display("FAIL mismatch_sda_driven: got %0d cycles expected 0", oe_cnt - oe_base); end
        checks++; if (st_cnt - base !== 0) begin failures++; $display("FAIL mismatch_no_strobe: got %0d expected 0", st_cnt - base); end
        loc_read(8'h10, d);
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL mismatch_reg10: got %h expected a5", d); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mismatch_busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_wrap;
        logic a0, a1, a2, a3;
        logic [7:0] d;
        int base = st_cnt;
        bus_start;
        bus_wbyte(8'h72, 1'b0, a0);
        bus_wbyte(8'h3F, 1'b0, a1);
        bus_wbyte(8'h11, 1'b0, a2);
        bus_wbyte(8'h22, 1'b0, a3);
        bus_stop;
        repeat (8) @(negedge clk);
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("FAIL wrap_acks: got %b expected 0000", {a0, a1, a2, a3}); end
        checks++; if (st_cnt - base !== 2) begin failures++; $display("FAIL wrap_strobe_count: got %0d expected 2", st_cnt - base); end
        checks++; if ({st_a[base], st_d[base]} !== 16'h3F11) begin failures++; $display("FAIL wrap_strobe0: got %h expected 3f11", {st_a[base], st_d[base]}); end
        checks++; if ({st_a[base+1], st_d[base+1]} !== 16'h4022) begin failures++; $display("FAIL wrap_strobe1: got %h expected 4022", {st_a[base+1], st_d[base+1]}); end
        loc_read(8'h3F, d);
        checks++; if (d !== 8'h11) begin failures++; $display("FAIL wrap_reg63: got %h expected 11", d); end
        loc_read(8'h00, d);
        checks++; if (d !== 8'h22) begin failures++; $display("FAIL wrap_reg0: got %h expected 22", d); end
    endtask

    task automatic test_aborted_byte;
        logic a, r;
        logic [7:0] d;
        int base = st_cnt;
        bus_start;
        bus_wbyte(8'h72, 1'b0, a);
        bus_wbyte(8'h20, 1'b0, a);
        bus_wbyte(8'h77, 1'b0, a);
        bus_wbyte(8'h88, 1'b0, a);
        bus_stop;
        bus_start;
        bus_wbyte(8'h72, 1'b0, a);
        bus_wbyte(8'h20, 1'b0, a);
        bus_wbyte(8'h99, 1'b0, a);
        bus_bit(1'b1, 1'b0, r);
        bus_bit(1'b1, 1'b0, r);
        bus_bit(1'b0, 1'b0, r);
        bus_bit(1'b0, 1'b0, r);
        bus_stop;
        repeat (8) @(negedge clk);
        checks++; if (st_cnt - base !== 3) begin failures++; $display("FAIL abort_strobe_count: got %0d expected 3", st_cnt - base); end
        checks++; if ({st_a[base+2], st_d[base+2]} !== 16'h2099) begin failures++; $display("FAIL abort_last_strobe: got %h expected 2099", {st_a[base+2], st_d[base+2]}); end
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL abort_sda_oe: got %b expected 0", sda_oe); end
        loc_read(8'h21, d);
        checks++; if (d !== 8'h88) begin failures++; $display("FAIL abort_reg21: got %h expected 88", d); end
        bus_start;
        bus_wbyte(8'h73, 1'b0, a);
        bus_rbyte(1'b1, d);
        bus_stop;
        repeat (8) @(negedge clk);
        checks++; if (d !== 8'h88) begin failures++; $display("FAIL abort_ptr_read: got %h expected 88", d); end
        checks++; if (st_cnt - base !== 3) begin failures++; $display("FAIL abort_read_no_strobe: got %0d expected 3", st_cnt - base); end
    endtask

    task automatic test_glitch;
        logic a;
        logic [7:0] d;
        logic [15:0] exp_st;
        int base = st_cnt;
`ifdef I2C_TGT_GLITCH_FILTER_EN
        exp_st = 16'h05A5;
`else
        // The extra SCL edge re-samples bit 7, so the byte closes one real bit early.
        exp_st = 16'h05D2;
`endif
        bus_start;
        bus_wbyte(8'h72, 1'b0, a);
        bus_wbyte(8'h05, 1'b0, a);
        bus_wbyte(8'hA5, 1'b1, a);
        bus_stop;
        repeat (8) @(negedge clk);
        checks++; if (st_cnt - base !== 1) begin failures++; $display("FAIL glitch_strobe_count: got %0d expected 1", st_cnt - base); end
        checks++; if ({st_a[base], st_d[base]} !== exp_st) begin failures++; $display("FAIL glitch_strobe: got %h expected %h", {st_a[base], st_d[base]}, exp_st); end
        loc_read(8'h05, d);
        checks++; if (d !== exp_st[7:0]) begin failures++; $display("FAIL glitch_reg05: got %h expected %h", d, exp_st[7:0]); end
    endtask

    task automatic test_reset_mid_read;
        logic a, r;
        logic [7:0] d;
        bus_start;
        bus_wbyte(8'h72, 1'b0, a);
        bus_wbyte(8'h30, 1'b0, a);
        bus_start;
        bus_wbyte(8'h73, 1'b0, a);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, 1'b0, r);
        for (int i = 0; i < 40 && sda_oe !== 1'b1; i++) @(negedge clk);
        checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL midread_oe_before_reset: got %b expected 1", sda_oe); end
        rstn = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL midread_oe_on_reset: got %b expected 0", sda_oe); end
        @(negedge clk);
        checks++; if ({busy, wr_addr, wr_data} !== 17'h0) begin failures++; $display("FAIL midread_reset_outputs: got %h expected 0", {busy, wr_addr, wr_data}); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        loc_read(8'h10, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL midread_reg10_cleared: got %h expected 00", d); end
        bus_stop;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_multi_write;
        test_read_rs;
        test_addr_mismatch;
        test_wrap;
        test_aborted_byte;
        test_glitch;
        test_reset_mid_read;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
